// File: rtl/div_seq16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, WIDTH steps.
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// BUSY  | shift-and-subtract iterations in progress
// DONE  | one-cycle result-valid pulse, then back to IDLE
module div_seq16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   d;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] shift_nxt;
    logic             last_step;

    // A restored partial remainder is always below the divisor, so its top bit
    // is zero and only WIDTH bits are kept; the trial subtract is WIDTH+1 wide.
    assign t         = {prem, shift[WIDTH-1]};
    assign d         = t - {1'b0, dvsr};
    assign rem_nxt   = d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];
    assign shift_nxt = {shift[WIDTH-2:0], ~d[WIDTH]};
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? DONE : BUSY;
            BUSY: if (last_step) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            BUSY: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            prem      <= '0;
            shift     <= '0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            shift <= dividend;
                            dvsr  <= divisor;
                            prem  <= '0;
                            cnt   <= '0;
                            div0  <= 1'b0;
                        end else begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div0      <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    prem  <= rem_nxt;
                    shift <= shift_nxt;
                    cnt   <= cnt + 1'b1;
                    // The final step's results go straight to the outputs.
                    if (last_step) begin
                        quotient  <= shift_nxt;
                        remainder <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq16.sv
// Directed and randomized checks of div_seq16 latency, results, start handling and reset.
module tb_div_seq16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div0;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int passes = 0;

    div_seq16 #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div0(div0)
    );

    always #5 clk = ~clk;

    // Called #1 after an edge with the DUT in IDLE; returns #1 after the accepting edge
    // with operands scrambled so any re-read of the ports would corrupt the result.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = 16'($urandom);
        divisor = 16'($urandom);
    endtask

    // lat: sample index at which done is seen (sample after accepting edge = 1); -1 on timeout.
    task automatic wait_done(output int lat, output int nbusy);
        int i;
        lat = -1;
        nbusy = 0;
        i = 1;
        while (i <= 40 && lat < 0) begin
            if (busy) nbusy++;
            if (done) lat = i;
            else begin
                @(posedge clk); #1;
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else passes++;
        checks++; if (quotient !== 16'h0) $display("FAIL reset_q got %h expected 0000", quotient); else passes++;
        checks++; if (remainder !== 16'h0) $display("FAIL reset_r got %h expected 0000", remainder); else passes++;
        checks++; if (div0 !== 1'b0) $display("FAIL reset_div0 got %b expected 0", div0); else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, nb;
        launch(16'd100, 16'd7);
        wait_done(lat, nb);
        checks++; if (lat !== 17) $display("FAIL basic_latency got %0d expected 17", lat); else passes++;
        checks++; if (nb !== 17) $display("FAIL basic_busy_cycles got %0d expected 17", nb); else passes++;
        checks++; if (quotient !== 16'd14) $display("FAIL basic_q got %0d expected 14", quotient); else passes++;
        checks++; if (remainder !== 16'd2) $display("FAIL basic_r got %0d expected 2", remainder); else passes++;
        checks++; if (div0 !== 1'b0) $display("FAIL basic_div0 got %b expected 0", div0); else passes++;
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL basic_idle got %b expected 00", {busy, done}); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        start = 1'b1;
        dividend = 16'hFFFF;
        divisor = 16'd1;
        @(posedge clk); #1;
        wait_done(lat, nb);
        checks++; if (lat !== 17) $display("FAIL b2b_first_latency got %0d expected 17", lat); else passes++;
        checks++; if (quotient !== 16'hFFFF) $display("FAIL b2b_first_q got %h expected ffff", quotient); else passes++;
        checks++; if (remainder !== 16'h0) $display("FAIL b2b_first_r got %h expected 0000", remainder); else passes++;
        dividend = 16'd3;
        divisor = 16'd10;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_gap got busy=%b expected 0", busy); else passes++;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_second_accept got busy=%b expected 1", busy); else passes++;
        checks++; if (quotient !== 16'hFFFF) $display("FAIL b2b_hold_q got %h expected ffff", quotient); else passes++;
        wait_done(lat, nb);
        checks++; if (lat !== 17) $display("FAIL b2b_second_latency got %0d expected 17", lat); else passes++;
        checks++; if (quotient !== 16'd0) $display("FAIL b2b_second_q got %0d expected 0", quotient); else passes++;
        checks++; if (remainder !== 16'd3) $display("FAIL b2b_second_r got %0d expected 3", remainder); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        int lat, nb;
        launch(16'd5, 16'd0);
        wait_done(lat, nb);
        checks++; if (lat !== 1) $display("FAIL div0_latency got %0d expected 1", lat); else passes++;
        checks++; if (quotient !== 16'hFFFF) $display("FAIL div0_q got %h expected ffff", quotient); else passes++;
        checks++; if (remainder !== 16'd5) $display("FAIL div0_r got %0d expected 5", remainder); else passes++;
        checks++; if (div0 !== 1'b1) $display("FAIL div0_flag got %b expected 1", div0); else passes++;
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL div0_idle got %b expected 00", {busy, done}); else passes++;
        launch(16'd9, 16'd3);
        wait_done(lat, nb);
        checks++; if (lat !== 17) $display("FAIL after_div0_latency got %0d expected 17", lat); else passes++;
        checks++; if (quotient !== 16'd3) $display("FAIL after_div0_q got %0d expected 3", quotient); else passes++;
        checks++; if (remainder !== 16'd0) $display("FAIL after_div0_r got %0d expected 0", remainder); else passes++;
        checks++; if (div0 !== 1'b0) $display("FAIL after_div0_flag got %b expected 0", div0); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        int ndone = 0;
        int at = -1;
        logic [15:0] q = '0, r = '0;
        launch(16'd1000, 16'd3);
        for (int i = 1; i <= 30; i++) begin
            if (done) begin
                ndone++;
                at = i;
                q = quotient;
                r = remainder;
            end
            if (i == 8) begin
                start = 1'b1;
                dividend = 16'd50;
                divisor = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        checks++; if (ndone !== 1) $display("FAIL ignored_done_count got %0d expected 1", ndone); else passes++;
        checks++; if (at !== 17) $display("FAIL ignored_latency got %0d expected 17", at); else passes++;
        checks++; if (q !== 16'd333) $display("FAIL ignored_q got %0d expected 333", q); else passes++;
        checks++; if (r !== 16'd1) $display("FAIL ignored_r got %0d expected 1", r); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL ignored_not_queued got busy=%b expected 0", busy); else passes++;
    endtask

    task automatic test_reset_mid();
        int lat, nb;
        int seen = 0;
        launch(16'hABCD, 16'h0012);
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL midrst_busy_done got %b expected 00", {busy, done}); else passes++;
        checks++; if (quotient !== 16'h0) $display("FAIL midrst_q got %h expected 0000", quotient); else passes++;
        checks++; if (remainder !== 16'h0) $display("FAIL midrst_r got %h expected 0000", remainder); else passes++;
        checks++; if (div0 !== 1'b0) $display("FAIL midrst_div0 got %b expected 0", div0); else passes++;
        for (int i = 0; i < 25; i++) begin
            if (done || busy) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) $display("FAIL midrst_no_done got %0d active cycles expected 0", seen); else passes++;
        launch(16'd20, 16'd6);
        wait_done(lat, nb);
        checks++; if (lat !== 17) $display("FAIL midrst_next_latency got %0d expected 17", lat); else passes++;
        checks++; if (quotient !== 16'd3) $display("FAIL midrst_next_q got %0d expected 3", quotient); else passes++;
        checks++; if (remainder !== 16'd2) $display("FAIL midrst_next_r got %0d expected 2", remainder); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, nb;
        logic [15:0] a, b, eq, er;
        logic ez;
        for (int n = 0; n < 300; n++) begin
            a = 16'($urandom);
            case (n % 4)
                0: b = 16'($urandom);
                1: b = 16'($urandom_range(1, 255));
                2: b = (n % 32 == 2) ? 16'd0 : 16'($urandom_range(1, 15));
                default: b = 16'($urandom_range(0, 3));
            endcase
            if (n == 5) a = 16'hFFFF;
            if (n == 7) b = 16'hFFFF;
            if (b == 16'd0) begin
                eq = 16'hFFFF; er = a; ez = 1'b1;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0;
            end
            launch(a, b);
            wait_done(lat, nb);
            checks++;
            if (lat !== ((b == 16'd0) ? 1 : 17))
                $display("FAIL rand_latency %h/%h got %0d", a, b, lat);
            else if ({quotient, remainder, div0} !== {eq, er, ez})
                $display("FAIL rand_result %h/%h got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         a, b, quotient, remainder, div0, eq, er, ez);
            else passes++;
            if (b != 16'd0) begin
                checks++;
                if ((32'(quotient) * 32'(b) + 32'(remainder) != 32'(a)) || (remainder >= b))
                    $display("FAIL rand_identity %h/%h got q=%h r=%h", a, b, quotient, remainder);
                else passes++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
